sig_period_meter: RTL

SIG_PERIOD_METER -- requirements
Module: sig_period_meter

---
 rtl/sig_period_meter_pkg.sv | 20 ++
 rtl/sig_period_meter_if.sv | 43 ++++
 rtl/sig_period_meter_sync_edge_det.sv | 42 ++++
 rtl/sig_period_meter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sig_period_meter_pkg.sv
// ----------------------------------------------------------------------------
// sig_period_meter_pkg : shared FSM encodings and default sizing
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sig_period_meter_pkg;

   localparam int          DEF_W         = 32;
   localparam int unsigned DEF_MAX_COUNT = 32'd100000000;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      MEASURE    = 2'd1,
      TIMEOUT    = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/sig_period_meter_if.sv
// ----------------------------------------------------------------------------
// sig_period_meter_if : measured input and result outputs of the period meter
// Optional HIGH_out present when SIG_PERIOD_METER_DUTY_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sig_period_meter_if
   import sig_period_meter_pkg::*;
#(
   parameter int W = DEF_W
) ();

   logic         SIG_in;
   logic [W-1:0] PERIOD_out;
   logic         VALID_out;
   logic         TIMEOUT_out;
`ifdef SIG_PERIOD_METER_DUTY_EN
   logic [W-1:0] HIGH_out;
`endif

   modport master (
      input  SIG_in,
`ifdef SIG_PERIOD_METER_DUTY_EN
      output HIGH_out,
`endif
      output PERIOD_out,
      output VALID_out,
      output TIMEOUT_out
   );

   modport slave (
      output SIG_in,
`ifdef SIG_PERIOD_METER_DUTY_EN
      input  HIGH_out,
`endif
      input  PERIOD_out,
      input  VALID_out,
      input  TIMEOUT_out
   );

endinterface

`default_nettype wire

// File: rtl/sig_period_meter_sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det : 2-FF synchronizer followed by a rising-edge detector
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_edge_det (
   input  logic CLK_in,
   input  logic RST_in,
   input  logic async_in,
   output logic rise,
   output logic level
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q,  prev_d;

   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge CLK_in) begin
      if (RST_in) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign rise  = sync2_q & ~prev_q;
   assign level = sync2_q;

endmodule

`default_nettype wire

// File: rtl/sig_period_meter.sv
// ----------------------------------------------------------------------------
// sig_period_meter : measures rising-to-rising period of SIG_in in clock cycles
// Optional high-time output enabled by SIG_PERIOD_METER_DUTY_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sig_period_meter
   import sig_period_meter_pkg::*;
#(
   parameter int          W         = DEF_W,
   parameter int unsigned MAX_COUNT = DEF_MAX_COUNT
) (
   input  logic                CLK_in,
   input  logic                RST_in,
   sig_period_meter_if.master  bus
);

   localparam logic [W-1:0] c_cnt_last = W'(MAX_COUNT - 1);
   localparam logic [W-1:0] c_one      = W'(1);

   logic w_rise;
   logic w_level;

   state_e       state_q,   state_d;
   logic [W-1:0] cnt_q,     cnt_d;
   logic [W-1:0] period_q,  period_d;
   logic         valid_q,   valid_d;
   logic         timeout_q, timeout_d;

   sync_edge_det u_sync_edge_det (
      .CLK_in   (CLK_in),
      .RST_in   (RST_in),
      .async_in (bus.SIG_in),
      .rise     (w_rise),
      .level    (w_level)
   );

`ifdef SIG_PERIOD_METER_DUTY_EN
   logic [W-1:0] high_q,     high_d;
   logic [W-1:0] high_cnt_q, high_cnt_d;
   logic [W-1:0] w_high_inc;

   assign w_high_inc = w_level ? c_one : '0;
`else
   logic w_unused;
   assign w_unused = w_level;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
`ifdef SIG_PERIOD_METER_DUTY_EN
      high_d     = high_q;
      high_cnt_d = high_cnt_q;
`endif
      case (state_q)
         WAIT_FIRST: begin
            if (w_rise) begin
               state_d = MEASURE;
               cnt_d   = '0;
`ifdef SIG_PERIOD_METER_DUTY_EN
               high_cnt_d = '0;
`endif
            end
         end
         MEASURE: begin
            // An edge on the last allowed count still completes the measurement.
            if (w_rise) begin
               period_d = cnt_q + c_one;
               valid_d  = 1'b1;
               cnt_d    = '0;
`ifdef SIG_PERIOD_METER_DUTY_EN
               high_d     = high_cnt_q + w_high_inc;
               high_cnt_d = '0;
`endif
            end else if (cnt_q == c_cnt_last) begin
               state_d   = TIMEOUT;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + c_one;
`ifdef SIG_PERIOD_METER_DUTY_EN
               high_cnt_d = high_cnt_q + w_high_inc;
`endif
            end
         end
         TIMEOUT: begin
            if (w_rise) begin
               state_d   = MEASURE;
               cnt_d     = '0;
               timeout_d = 1'b0;
`ifdef SIG_PERIOD_METER_DUTY_EN
               high_cnt_d = '0;
`endif
            end
         end
         default: state_d = WAIT_FIRST;
      endcase
   end

   always_ff @(posedge CLK_in) begin
      if (RST_in) begin
         state_q   <= WAIT_FIRST;
         cnt_q     <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

`ifdef SIG_PERIOD_METER_DUTY_EN
   always_ff @(posedge CLK_in) begin
      if (RST_in) begin
         high_q     <= '0;
         high_cnt_q <= '0;
      end else begin
         high_q     <= high_d;
         high_cnt_q <= high_cnt_d;
      end
   end

   assign bus.HIGH_out = high_q;
`endif

   assign bus.PERIOD_out  = period_q;
   assign bus.VALID_out   = valid_q;
   assign bus.TIMEOUT_out = timeout_q;

endmodule

`default_nettype wire
